// File: rtl/sig_delay_ctrl.sv
// Programmable delay-line sequencer for a 2-port sample RAM: writes samples at a
// circular pointer and reads back the sample written delay_q samples earlier.
module sig_delay_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     start,
   input  logic                     stop,
   input  logic [ADDRESS_WIDTH-1:0] delay,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic                     ram_wr,
   output logic                     ram_rd,
   output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
   output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     running
);

   localparam int unsigned AW = ADDRESS_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] fill_cnt_q, fill_cnt_d;
   logic [AW-1:0] delay_q, delay_d;
   logic          dout_valid_q, dout_valid_d;

   // An en coinciding with stop is dropped entirely, so every strobe is gated by !stop.
   logic wr_c;
   logic rd_c;
   assign wr_c = en & ~stop & ((state_q == FILL) | (state_q == RUN));
   assign rd_c = en & ~stop & (state_q == RUN);

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      fill_cnt_d   = fill_cnt_q;
      delay_d      = delay_q;
      dout_valid_d = rd_c;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               delay_d    = (delay == '0) ? AW'(1) : delay;
               wr_ptr_d   = '0;
               fill_cnt_d = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (stop) begin
               state_d = IDLE;
            end else if (en) begin
               wr_ptr_d   = wr_ptr_q + AW'(1);
               fill_cnt_d = fill_cnt_q + AW'(1);
               // this en writes the delay_q-th sample, so reads may start with the next one
               if (fill_cnt_q == delay_q - AW'(1)) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (en) begin
               wr_ptr_d = wr_ptr_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         fill_cnt_q   <= '0;
         delay_q      <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_cnt_q   <= fill_cnt_d;
         delay_q      <= delay_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign ram_wr      = wr_c;
   assign ram_rd      = rd_c;
   assign ram_wr_addr = wr_ptr_q;
   assign ram_rd_addr = rd_c ? (wr_ptr_q - delay_q) : '0;
   assign ram_din     = din;
   assign dout        = ram_dout;
   assign dout_valid  = dout_valid_q;
   assign busy        = (state_q != IDLE);
   assign running     = (state_q == RUN);

endmodule
